// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Results are computed from latched operands and committed on the last RUN cycle.
module muldiv_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  localparam logic [3:0] MultLoad = 4'(MULT_CYCLES);
  localparam logic [3:0] DivLoad  = 4'(DIV_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  logic        is_unsigned, is_div;
  logic [63:0] mul_a, mul_b, prod;
  logic        neg_a, neg_b;
  logic [31:0] abs_a, abs_b, divisor, uq, ur, quot, rem;
  logic [31:0] res_hi, res_lo;

  // Result datapath, driven only by the latched operands.
  always_comb begin
    is_unsigned = op_q[0];
    is_div      = op_q[1];
    mul_a       = is_unsigned ? {32'b0, a_q} : {{32{a_q[31]}}, a_q};
    mul_b       = is_unsigned ? {32'b0, b_q} : {{32{b_q[31]}}, b_q};
    prod        = mul_a * mul_b;
    neg_a       = ~is_unsigned & a_q[31];
    neg_b       = ~is_unsigned & b_q[31];
    abs_a       = neg_a ? (32'd0 - a_q) : a_q;
    abs_b       = neg_b ? (32'd0 - b_q) : b_q;
    // Keep the divider well-defined on zero; the zero case is overridden below.
    divisor     = (b_q == 32'd0) ? 32'd1 : abs_b;
    uq          = abs_a / divisor;
    ur          = abs_a % divisor;
    quot        = (neg_a ^ neg_b) ? (32'd0 - uq) : uq;
    rem         = neg_a ? (32'd0 - ur) : ur;
    if (!is_div) begin
      res_hi = prod[63:32];
      res_lo = prod[31:0];
    end else if (b_q == 32'd0) begin
      res_hi = a_q;
      res_lo = 32'hFFFF_FFFF;
    end else begin
      res_hi = rem;
      res_lo = quot;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          op_d    = op;
          a_d     = a;
          b_d     = b;
          cnt_d   = op[1] ? DivLoad : MultLoad;
          state_d = StRun;
        end else begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end
      StRun: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          hi_d    = res_hi;
          lo_d    = res_lo;
          state_d = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      op_q    <= 2'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == StRun);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: busy length, HI/LO results, write/issue rules, reset abort.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, start, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        busy;
  logic [31:0] hi, lo;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] m_hi, m_lo;

  muldiv_unit #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .hi_we(hi_we),
    .lo_we(lo_we),
    .wdata(wdata),
    .busy (busy),
    .hi   (hi),
    .lo   (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; issues now, tracks busy, checks HI/LO hold and final values.
  // mid: 0 none, 1 mthi on 2nd busy cycle, 2 second start on 2nd busy cycle.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input int n, input logic [31:0] eh,
                        input logic [31:0] el, input int mid);
    int cnt;
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(negedge clk);
    start = 1'b0;
    lo_we = 1'b0;
    hi_we = 1'b0;
    op    = 2'b00;
    a     = 32'hDEAD_BEEF;
    b     = 32'h0000_0000;
    cnt   = 0;
    while (busy && cnt < 40) begin
      cnt++;
      check({tag, "_hold_hi"}, hi, m_hi);
      check({tag, "_hold_lo"}, lo, m_lo);
      hi_we = 1'b0;
      start = 1'b0;
      if (mid == 1 && cnt == 2) begin
        hi_we = 1'b1;
        wdata = 32'h0000_DEAD;
      end
      if (mid == 2 && cnt == 2) begin
        start = 1'b1;
        op    = 2'b11;
        a     = 32'd100;
        b     = 32'd7;
      end
      @(negedge clk);
    end
    start = 1'b0;
    hi_we = 1'b0;
    check({tag, "_busy_cycles"}, 32'(cnt), 32'(n));
    check({tag, "_hi"}, hi, eh);
    check({tag, "_lo"}, lo, el);
    m_hi = eh;
    m_lo = el;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    op    = 2'b00;
    a     = 32'd0;
    b     = 32'd0;
    wdata = 32'd0;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    rst  = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;

    run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7, 5, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,
           32'hFFFF_FFFE, 32'h0000_0001, 0);
    run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    run_op("divu_7_2", 2'b11, 32'd7, 32'd2, 10, 32'd1, 32'd3, 0);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000, 0);
    run_op("divu_by0", 2'b11, 32'd5, 32'd0, 10, 32'd5, 32'hFFFF_FFFF, 0);
    run_op("div_by0", 2'b10, 32'hFFFF_FFF0, 32'd0, 10, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 0);

    // mthi / mtlo in IDLE
    hi_we = 1'b1;
    wdata = 32'h0000_1234;
    @(negedge clk);
    hi_we = 1'b0;
    check("mthi_hi", hi, 32'h0000_1234);
    check("mthi_lo_kept", lo, 32'hFFFF_FFFF);
    lo_we = 1'b1;
    wdata = 32'h0000_5678;
    @(negedge clk);
    lo_we = 1'b0;
    check("mtlo_lo", lo, 32'h0000_5678);
    check("mtlo_hi_kept", hi, 32'h0000_1234);
    hi_we = 1'b1;
    lo_we = 1'b1;
    wdata = 32'h0000_ABCD;
    @(negedge clk);
    hi_we = 1'b0;
    lo_we = 1'b0;
    check("mthilo_hi", hi, 32'h0000_ABCD);
    check("mthilo_lo", lo, 32'h0000_ABCD);
    m_hi = 32'h0000_ABCD;
    m_lo = 32'h0000_ABCD;

    run_op("div_mthi_mid", 2'b10, 32'd100, 32'd7, 10, 32'd2, 32'd14, 1);
    lo_we = 1'b1;
    wdata = 32'h0000_7777;
    run_op("mtlo_with_start", 2'b11, 32'd20, 32'd3, 10, 32'd2, 32'd6, 0);
    run_op("restart_ignored", 2'b00, 32'd3, 32'd4, 5, 32'd0, 32'd12, 2);
    @(negedge clk);
    check("restart_no_issue", 32'(busy), 32'd0);

    // Reset on the third busy cycle of a multu
    start = 1'b1;
    op    = 2'b01;
    a     = 32'd5;
    b     = 32'd6;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_abort_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    repeat (12) @(negedge clk);
    check("abort_late_busy", 32'(busy), 32'd0);
    check("abort_late_hi", hi, 32'd0);
    check("abort_late_lo", lo, 32'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;

    run_op("b2b_mult", 2'b00, 32'd2, 32'd3, 5, 32'd0, 32'd6, 0);
    run_op("b2b_divu", 2'b11, 32'd9, 32'd4, 10, 32'd1, 32'd2, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle multiply/divide unit for the 5-stage MIPS core, with its architectural HI/LO registers. It is the producer side of the `muldiv` instruction class that the hazard/forwarding control decodes. It executes mult/multu/div/divu issued from the E stage and services mthi/mtlo writes. It exposes `busy` so the stall logic can hold mfhi/mflo and further muldiv instructions in D until results are committed.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: cycles `busy` stays high for mult/multu; legal range 1..15.
- `DIV_CYCLES`, default 10: cycles `busy` stays high for div/divu; legal range 1..15.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `start` input 1: issue request from E stage for a muldiv operation.
- `op` input 2: operation select. 00 = mult, 01 = multu, 10 = div, 11 = divu.
- `a` input 32: rs operand (dividend or multiplicand).
- `b` input 32: rt operand (divisor or multiplier).
- `hi_we` input 1: mthi write enable.
- `lo_we` input 1: mtlo write enable.
- `wdata` input 32: mthi/mtlo data.
- `busy` output 1: operation in flight.
- `hi` output 32: HI register, registered.
- `lo` output 32: LO register, registered.

## Operation
- Two states: IDLE (`busy` = 0) and RUN (`busy` = 1). A 4-bit down-counter holds the remaining cycles.
- IDLE with `start` = 1:
  - Latch `op`, `a` and `b`.
  - Load the counter with MULT_CYCLES or DIV_CYCLES.
  - Go to RUN.
- RUN:
  - Decrement the counter each cycle.
  - When the counter reaches its final cycle, write HI/LO from the latched operands and return to IDLE.
- `start` while in RUN is ignored. No queueing and no error flag; the stall logic must prevent it.
- `hi_we`/`lo_we` in IDLE with `start` = 0: write `wdata` to HI/LO at the edge. Both may be asserted in the same cycle.
- `hi_we`/`lo_we` while in RUN is ignored.
- `hi_we`/`lo_we` in the same cycle as an accepted `start`: `start` wins and the writes are dropped.
- Arithmetic rules:
  - mult: signed 32x32 to 64-bit product. HI = product[63:32], LO = product[31:0].
  - multu: same as mult, unsigned.
  - div: signed division. LO = quotient, truncated toward zero. HI = remainder, which takes the dividend's sign.
  - div with 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
  - divu: unsigned division. LO = quotient, HI = remainder.
  - Divide by zero, for both div and divu: LO = 0xFFFFFFFF, HI = `a`.
- The result is computed from the latched operands only. Changes to `a`, `b` or `op` after issue have no effect.
- The implementation may compute the result combinationally at commit or iteratively during RUN. Only the commit cycle and the values are visible.

## Timing
- Reset state: `busy` = 0, `hi` = 0, `lo` = 0, counter = 0, state IDLE.
- `rst` is asserted in RUN: abort the operation. The next state is the reset state and the result is never committed.
- `start` accepted at edge k, with N = MULT_CYCLES or DIV_CYCLES:
  - `busy` = 1 after edges k through k+N-1, i.e. for exactly N cycles.
  - `hi`/`lo` update at edge k+N, and `busy` = 0 after that edge.
  - N = 1: `busy` is high for one cycle and the commit happens at edge k+1.
- Back-to-back issue: a new `start` is accepted in the first cycle after `busy` falls, so there is no dead cycle.
- mthi/mtlo latency: the `hi`/`lo` outputs change one edge after `hi_we`/`lo_we`.
- There is no combinational path from inputs to outputs.

## Test plan
- Reset, then mult with a = 0xFFFFFFFD, b = 7:
  - `busy` is high for exactly 5 cycles.
  - Then `hi` = 0xFFFFFFFF and `lo` = 0xFFFFFFEB.
  - `hi`/`lo` are unchanged while `busy` is high.
- Multiply and divide results:
  - multu 0xFFFFFFFF * 0xFFFFFFFF: `hi` = 0xFFFFFFFE, `lo` = 0x00000001.
  - div -7 / 2 (0xFFFFFFF9, 2): `lo` = 0xFFFFFFFD, `hi` = 0xFFFFFFFF after 10 busy cycles.
  - divu 7 / 2: `lo` = 3, `hi` = 1.
- Division corner cases:
  - div 0x80000000 / 0xFFFFFFFF: `lo` = 0x80000000, `hi` = 0.
  - divu 5 / 0: `lo` = 0xFFFFFFFF, `hi` = 5.
- Write and issue rules:
  - mthi 0x1234 and mtlo 0x5678 while IDLE: `hi`/`lo` take these values on the next edge.
  - Repeat mthi during a div: the write is ignored and the div result commits.
  - mtlo asserted together with `start`: the write is dropped.
  - A second `start` mid-operation is ignored: `busy` length and the result are those of the first operation.
- Reset in RUN:
  - Assert `rst` on the third busy cycle of a multu: `busy` = 0 and `hi` = `lo` = 0 next cycle, and nothing commits later.
  - Then issue mult 2 * 3 back-to-back with a divu 9 / 4 in the cycle `busy` falls: results are `lo` = 6, `hi` = 0, then `lo` = 2, `hi` = 1.
